// File: rtl/serial_shifter_32_bit_pkg.sv
// Shared definitions for the serial 32-bit shifter.
//
// Holds the default operand/shift widths, the operation encoding
// used on the Op port and the FSM state encoding shared by the
// top-level shifter and its single-step sub-module.
package serial_shifter_32_bit_pkg;

    // Default operand width and shift-count width (DATA_BITS == 2**SHIFT_BITS).
    localparam int DATA_BITS  = 32;
    localparam int SHIFT_BITS = 5;

    // Operation encoding presented on Op and held in the op register.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/serial_shifter_32_bit_shift_step_1_bit.sv
// Single-bit shift step for the serial shifter.
//
// Purely combinational: moves value by one bit position according to
// the selected operation.
//
// Ports:
//   value    in   DataBits  current working value
//   Op       in   2         operation (OP_SLL/OP_SRL/OP_SRA/OP_ROL)
//   stepped  out  DataBits  value after one shift step
module shift_step_1_bit
    import serial_shifter_32_bit_pkg::*;
#(
    parameter int DataBits = DATA_BITS
) (
    input  logic [DataBits-1:0] value,
    input  logic [1:0]          Op,
    output logic [DataBits-1:0] stepped
);

    // NOTE: the default assignment at the top of the block guarantees every
    // path drives stepped, so no latch can be inferred.
    always_comb begin
        stepped = value;
        case (op_e'(Op))
            OP_SLL:  stepped = {value[DataBits-2:0], 1'b0};
            OP_SRL:  stepped = {1'b0, value[DataBits-1:1]};
            OP_SRA:  stepped = {value[DataBits-1], value[DataBits-1:1]};
            OP_ROL:  stepped = {value[DataBits-2:0], value[DataBits-1]};
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/serial_shifter_32_bit.sv
// Serial (one bit per clock) barrel-shift replacement.
//
// An operand is accepted in IDLE when Start is high. The working
// register is then shifted one bit per clock for ShiftAmount cycles;
// a zero amount goes straight to DONE. The result is held in DONE until
// ResultAck is seen. Inputs other than ResultAck are ignored while busy.
//
// Ports:
//   clock        in   1          rising-edge clock
//   reset        in   1          synchronous, active-high reset
//   Start        in   1          begin a shift (sampled only in IDLE)
//   DataA        in   DataBits   operand, captured on accept
//   ShiftAmount  in   ShiftBits  shift count, captured on accept
//   Op           in   2          00 SLL, 01 SRL, 10 SRA, 11 ROL
//   Ready        out  1          high only in IDLE
//   Busy         out  1          high in SHIFT or DONE
//   ResultValid  out  1          high only in DONE
//   ResultAck    in   1          consumer acknowledge of Result
//   Result       out  DataBits   shifted value, valid while ResultValid=1
module serial_shifter_32_bit
    import serial_shifter_32_bit_pkg::*;
#(
    parameter int DataBits  = DATA_BITS,
    parameter int ShiftBits = SHIFT_BITS   // DataBits must equal 2**ShiftBits
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 Start,
    input  logic [DataBits-1:0]  DataA,
    input  logic [ShiftBits-1:0] ShiftAmount,
    input  logic [1:0]           Op,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 ResultValid,
    input  logic                 ResultAck,
    output logic [DataBits-1:0]  Result
);

    state_e                state;
    logic [DataBits-1:0]   work;
    logic [ShiftBits-1:0]  count;
    op_e                   op;
    logic                  ready_q;
    logic                  busy_q;
    logic                  valid_q;
    logic [DataBits-1:0]   stepped;

    shift_step_1_bit #(
        .DataBits (DataBits)
    ) u_step (
        .value   (work),
        .Op      (op),
        .stepped (stepped)
    );

    // NOTE: all state here is flops written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    // NOTE: every register, including the datapath, is cleared on reset so an
    // aborted shift leaves Result at zero rather than a stale partial value.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            work    <= '0;
            count   <= '0;
            op      <= OP_SLL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        work    <= DataA;
                        count   <= ShiftAmount;
                        op      <= op_e'(Op);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        // A zero count has nothing to shift: present DataA directly.
                        if (ShiftAmount == '0) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state   <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    work  <= stepped;
                    count <= count - 1'b1;
                    // Leave on the step that consumes the last count, so the
                    // counter lands on zero and never wraps.
                    if (count == ShiftBits'(1)) begin
                        state   <= ST_DONE;
                        valid_q <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // Start is deliberately not looked at here: no back-to-back accept.
                    if (ResultAck) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Ready       = ready_q;
    assign Busy        = busy_q;
    assign ResultValid = valid_q;
    assign Result      = work;

endmodule

// File: doc/serial_shifter_32_bit.md
SERIAL_SHIFTER_32_BIT -- requirements
Module: serial_shifter_32_bit

Interface
REQ-001 Parameter DataBits, default 32: operand and result width.
REQ-002 Parameter ShiftBits, default 5: shift-amount width; DataBits SHALL equal 2**ShiftBits.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to begin a shift; sampled only in IDLE.
REQ-006 DataA  input  DataBits  operand, captured on accept.
REQ-007 ShiftAmount  input  ShiftBits  shift count, captured on accept.
REQ-008 Op  input  2  operation, captured on accept: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-009 Ready  output  1  high only in IDLE.
REQ-010 Busy  output  1  high in SHIFT or DONE.
REQ-011 ResultValid  output  1  high only in DONE.
REQ-012 ResultAck  input  1  consumer acknowledge of Result.
REQ-013 Result  output  DataBits  shifted value; defined while ResultValid=1.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 Accept: IDLE with Start=1 SHALL load the working register with DataA, the counter with ShiftAmount and the op register with Op at that edge.
REQ-016 Accept with ShiftAmount=0 SHALL go IDLE->DONE, with Result equal to DataA.
REQ-017 Accept with ShiftAmount=k, k>0, SHALL go IDLE->SHIFT.
REQ-018 Each SHIFT edge SHALL shift the working register by exactly one bit per the latched Op and decrement the counter.
REQ-019 SHIFT SHALL go to DONE at the edge where the counter decrements from 1 to 0.
REQ-020 Latency: ResultValid SHALL rise max(k,1) cycles after the accept edge.
REQ-021 Per-step rules:
- SLL: fill LSB with 0.
- SRL: fill MSB with 0.
- SRA: fill MSB with a copy of the current MSB.
- ROL: fill LSB with the MSB shifted out.
REQ-022 Result SHALL equal the working register and SHALL hold stable throughout DONE.
REQ-023 DONE SHALL go to IDLE at the first edge with ResultAck=1; ResultValid SHALL drop at that edge.
REQ-024 Start outside IDLE SHALL be ignored, including Start and ResultAck high in the same DONE cycle; no back-to-back accept.
REQ-025 ResultAck outside DONE SHALL be ignored.
REQ-026 DataA, ShiftAmount and Op changing after accept SHALL NOT affect the operation in progress.
REQ-027 A full-range count, ShiftAmount=DataBits-1, SHALL complete correctly; the counter SHALL never wrap.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE and clear the working register, counter and op register to 0.
REQ-029 Reset values: Ready=1, Busy=0, ResultValid=0, Result=0.
REQ-030 Reset SHALL take priority over Start and ResultAck and SHALL abort an in-progress shift with no result produced.

Structure
REQ-031 A shared package SHALL hold the Op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROL), the state encoding and the DataBits/ShiftBits defaults.
REQ-032 One combinational sub-module, shift_step_1_bit, SHALL implement the single-bit step of REQ-021 (inputs: value, Op; output: stepped value).
REQ-033 serial_shifter_32_bit SHALL instantiate shift_step_1_bit once and contain the FSM, counter and registers.

Verification
REQ-034 SLL, DataA=0x00000001, amount 31 -> ResultValid 31 cycles after accept, Result=0x80000000.
REQ-035 SRA 0x80000000 by 4 -> 0xF8000000; SRL 0x80000000 by 4 -> 0x08000000; each valid 4 cycles after accept.
REQ-036 ROL 0x80000001 by 1 -> 0x00000003 after 1 cycle; amount 0, DataA=0x12345678 -> 0x12345678 after 1 cycle.
REQ-037 Start pulsed and DataA changed during SHIFT/DONE; ResultAck delayed 5 cycles -> original result unchanged, held for all 5 cycles, no second operation, Ready=1 only after ack.
REQ-038 reset asserted mid-SHIFT (SLL by 20, cycle 7) -> next cycle IDLE, Ready=1, ResultValid=0, Result=0; a new accept then completes normally.
